// File: rtl/debug_run_controller.sv
// Run/halt/single-step control with PC breakpoint, auto-scanning register
// display and a saturating count of processor-enabled cycles.
module debug_run_controller #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4,
    parameter int SCAN_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              bp_enable,
    input  logic [DATA_W-1:0] bp_addr,
    input  logic [DATA_W-1:0] fetch_pc,
    input  logic              scan_en,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [DATA_W-1:0] reg_data,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [SEL_W-1:0]  reg_sel,
    output logic [DATA_W-1:0] debug_out,
    output logic [CNT_W-1:0]  en_count
);

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_HALT   = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_RESUME = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W:0]   SEL_NUM  = (SEL_W + 1)'(NUM_REGS);

    logic [2:0]       state, state_nxt;
    logic             primed;
    logic             run_s1, run_s2, step_s1, step_s2;
    logic             run_rise, step_rise, match;
    logic [DIV_W-1:0] div;
    logic [SEL_W-1:0] sel_clamped;

    // On the first edge after reset both stages load the input, so a request
    // already held high at reset release does not register as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed  <= 1'b0;
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
        end else begin
            primed  <= 1'b1;
            run_s1  <= run_req;
            step_s1 <= step_req;
            run_s2  <= primed ? run_s1 : run_req;
            step_s2 <= primed ? step_s1 : step_req;
        end
    end

    assign run_rise  = run_s1 & ~run_s2;
    assign step_rise = step_s1 & ~step_s2;
    assign match     = bp_enable && (fetch_pc == bp_addr);

    always_comb begin
        state_nxt = state;
        if (halt_req) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_RUN:             if (match) state_nxt = ST_BREAK;
                ST_HALT, ST_BREAK: begin
                    if (step_rise)     state_nxt = ST_STEP;
                    else if (run_rise) state_nxt = ST_RESUME;
                end
                ST_STEP:            state_nxt = ST_HALT;
                ST_RESUME:          state_nxt = ST_RUN;
                default:            state_nxt = ST_HALT;
            endcase
        end
    end

    // In RUN the enable drops as soon as the breakpoint PC is fetched, so the
    // breakpointed instruction never executes.
    always_comb begin
        cpu_en = 1'b0;
        case (state)
            ST_RUN:               cpu_en = !match;
            ST_STEP, ST_RESUME:   cpu_en = 1'b1;
            default:              cpu_en = 1'b0;
        endcase
    end

    assign halted = (state == ST_HALT) || (state == ST_BREAK);
    assign bp_hit = (state == ST_BREAK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_HALT;
            en_count <= '0;
        end else begin
            state <= state_nxt;
            if (cpu_en && (en_count != {CNT_W{1'b1}}))
                en_count <= en_count + CNT_W'(1);
        end
    end

    assign sel_clamped = ({1'b0, sel_in} >= SEL_NUM) ? SEL_LAST : sel_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div       <= '0;
            reg_sel   <= '0;
            debug_out <= '0;
        end else begin
            debug_out <= reg_data;
            if (scan_en) begin
                if (div == DIV_LAST) begin
                    div     <= '0;
                    reg_sel <= (reg_sel == SEL_LAST) ? '0 : reg_sel + SEL_W'(1);
                end else begin
                    div <= div + DIV_W'(1);
                end
            end else begin
                div     <= '0;
                reg_sel <= sel_clamped;
            end
        end
    end

endmodule

// File: tb/tb_debug_run_controller.sv
// Randomized bench for debug_run_controller against a cycle-level model of the
// run-control rules, breakpoint, register scan and saturating counter.
module tb_debug_run_controller;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 12;
    localparam int SEL_W    = 4;
    localparam int SCAN_DIV = 3;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              run_req, halt_req, step_req, bp_enable, scan_en;
    logic [DATA_W-1:0] bp_addr, fetch_pc, reg_data;
    logic [SEL_W-1:0]  sel_in;
    logic              cpu_en, halted, bp_hit;
    logic [SEL_W-1:0]  reg_sel;
    logic [DATA_W-1:0] debug_out;
    logic [CNT_W-1:0]  en_count;

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rdata(input int s);
        return 32'hD00D_0000 + 32'(s) * 32'h0000_1111;
    endfunction

    assign reg_data = rdata(int'(reg_sel));

    debug_run_controller #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
        .SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_enable(bp_enable), .bp_addr(bp_addr),
        .fetch_pc(fetch_pc), .scan_en(scan_en), .sel_in(sel_in),
        .reg_data(reg_data), .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit),
        .reg_sel(reg_sel), .debug_out(debug_out), .en_count(en_count)
    );

    typedef enum {M_RUN, M_HALT, M_STEP, M_RESUME, M_BREAK} mode_t;

    mode_t       m;
    int          cnt, msel, held;
    logic [31:0] mdbg;
    bit          rh[$], sh[$];
    bit          last_en;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m = M_HALT; cnt = 0; msel = 0; held = 0; mdbg = '0;
        rh.delete(); sh.delete();
        last_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".cpu_en"},    cpu_en,    1'b0);
        chk({tag, ".halted"},    halted,    1'b1);
        chk({tag, ".bp_hit"},    bp_hit,    1'b0);
        chk({tag, ".en_count"},  en_count,  '0);
        chk({tag, ".reg_sel"},   reg_sel,   '0);
        chk({tag, ".debug_out"}, debug_out, '0);
    endtask

    // Entered at a falling edge: drive, check, advance model, reach next falling edge.
    task automatic cycle(input bit r, input bit h, input bit s, input bit be,
                         input logic [31:0] ba, input bit sc, input int sl);
        bit    match, exp_en, rr, sr;
        int    n;
        mode_t nxt;
        run_req = r; halt_req = h; step_req = s; bp_enable = be;
        bp_addr = ba; scan_en = sc; sel_in = SEL_W'(sl);
        #1;
        match  = be && (fetch_pc == ba);
        exp_en = (m == M_RUN) ? !match : (m == M_STEP || m == M_RESUME);
        chk("cpu_en",    cpu_en,    exp_en);
        chk("halted",    halted,    (m == M_HALT || m == M_BREAK));
        chk("bp_hit",    bp_hit,    (m == M_BREAK));
        chk("en_count",  en_count,  cnt);
        chk("reg_sel",   reg_sel,   msel);
        chk("debug_out", debug_out, mdbg);

        n  = rh.size();
        rr = (n >= 2) && rh[n-1] && !rh[n-2];
        sr = (n >= 2) && sh[n-1] && !sh[n-2];
        rh.push_back(r);
        sh.push_back(s);
        nxt = m;
        if (h)                                nxt = M_HALT;
        else if (m == M_RUN)                  nxt = match ? M_BREAK : M_RUN;
        else if (m == M_HALT || m == M_BREAK) nxt = sr ? M_STEP : (rr ? M_RESUME : m);
        else if (m == M_STEP)                 nxt = M_HALT;
        else                                  nxt = M_RUN;
        m = nxt;
        if (exp_en && cnt < CNT_MAX) cnt++;
        mdbg = rdata(msel);
        if (sc) begin
            held++;
            if (held == SCAN_DIV) begin
                held = 0;
                msel = (msel + 1) % NUM_REGS;
            end
        end else begin
            held = 0;
            msel = (sl >= NUM_REGS) ? NUM_REGS - 1 : sl;
        end

        last_en = cpu_en;
        @(negedge clk);
        if (last_en) fetch_pc += 4;
    endtask

    task automatic idle(input int k, input bit be, input logic [31:0] ba);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, be, ba, 0, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset(input string tag, input bit hold_run);
        #2 reset = 1'b1;
        run_req = hold_run;
        #1 check_reset_outputs(tag);
        fetch_pc = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] ba;
        reset = 1'b1;
        run_req = 0; halt_req = 0; step_req = 0; bp_enable = 0;
        bp_addr = '0; fetch_pc = '0; scan_en = 0; sel_in = '0;
        model_reset();
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single step pulse, then a step held high
        cycle(0, 0, 1, 0, 0, 0, 0);
        idle(5, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, 0, 0);
        idle(3, 0, 0);

        // free run into a breakpoint four instructions ahead, then resume past it
        ba = fetch_pc + 32'd16;
        cycle(1, 0, 0, 1, ba, 0, 0);
        idle(9, 1, ba);
        chk("bp.fetch_pc", fetch_pc, ba);
        cycle(1, 0, 0, 1, ba, 0, 0);
        idle(6, 1, ba);

        // halt wins over a step edge; simultaneous run+step edges step once
        cycle(0, 1, 1, 0, 0, 0, 0);
        idle(3, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        idle(4, 0, 0);

        // manual select with clamping, then scan from a high register
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 7);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 15);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 10);
        for (int i = 0; i < 4 * SCAN_DIV + 2; i++) cycle(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, 3);

        // long free run saturates the counter, then reset mid-run
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(40, 0, 0);
        async_reset("midrun", 1'b1);
        // run_req still high across release must not start the processor
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // randomized traffic
        ba = 32'd24;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) ba = fetch_pc + 4 * $urandom_range(0, 8);
            if ($urandom_range(0, 499) == 0) async_reset("rnd_reset", 1'b0);
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, ba,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
